// File: rtl/hilo_muldiv_pkg.sv
// Shared op codes, FSM states and default widths for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    localparam int HILO_DW    = 32;
    localparam int HILO_CNT_W = 5;

    typedef enum logic [2:0] {
        HILO_MULT  = 3'd0,
        HILO_MULTU = 3'd1,
        HILO_DIV   = 3'd2,
        HILO_DIVU  = 3'd3,
        HILO_MTHI  = 3'd4,
        HILO_MTLO  = 3'd5
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } hilo_state_e;

    function automatic logic is_div(input logic [2:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// EX-stage bundle between the pipeline (master) and the HI/LO unit (slave).
interface hilo_muldiv_if #(parameter int DW = 32);

    logic          op_valid;
    logic [2:0]    op_sel;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic          flush;
    logic          stall;
    logic          busy;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    modport master (
        output op_valid, op_sel, src_a, src_b, flush,
        input  stall, busy, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op_sel, src_a, src_b, flush,
        output stall, busy, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_muldiv_div_radix2.sv
// Iterative restoring divider, one quotient bit per cycle on operand magnitudes;
// done/quo/rem are combinational on the final step so the owner can latch them that edge.
module div_radix2 #(
    parameter int DW    = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          signed_en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          abort,
    output logic          done,
    output logic [DW-1:0] quo,
    output logic [DW-1:0] rem
);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    rem_q, quo_q, dvs_q;
    logic             sign_q, sign_r;

    logic          neg_a, neg_b;
    logic [DW-1:0] abs_a, abs_b;
    logic [DW:0]   shifted, trial;
    logic [DW-1:0] rem_n, quo_n;

    assign neg_a = signed_en & a[DW-1];
    assign neg_b = signed_en & b[DW-1];
    assign abs_a = neg_a ? -a : a;
    assign abs_b = neg_b ? -b : b;

    // rem < divisor always holds, so the shifted partial remainder fits DW+1 bits
    // and bit DW of the trial difference is a clean borrow flag.
    always_comb begin
        shifted = {rem_q, quo_q[DW-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (trial[DW]) begin
            rem_n = shifted[DW-1:0];
            quo_n = {quo_q[DW-2:0], 1'b0};
        end else begin
            rem_n = trial[DW-1:0];
            quo_n = {quo_q[DW-2:0], 1'b1};
        end
    end

    assign done = running & (cnt == CNT_W'(DW-1));
    assign quo  = sign_q ? -quo_n : quo_n;
    assign rem  = sign_r ? -rem_n : rem_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= abs_a;
            dvs_q   <= abs_b;
            sign_q  <= neg_a ^ neg_b;
            sign_r  <= neg_a;
        end else if (running) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            if (abort || done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, iterative DIV/DIVU that
// stalls the pipeline until the quotient/remainder land in LO/HI.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int DW    = HILO_DW,
    parameter int CNT_W = HILO_CNT_W
) (
    input logic            clk,
    input logic            rst,
    hilo_muldiv_if.slave   bus
);

    hilo_state_e   state;
    logic [DW-1:0] hi_q, lo_q;

    logic          fire, div_start, div_done;
    logic [DW-1:0] div_quo, div_rem;

    logic                 mul_signed;
    logic signed [DW:0]   mul_a, mul_b;
    logic [2*DW-1:0]      prod;

    assign fire      = (state == ST_IDLE) & bus.op_valid & ~bus.flush;
    assign div_start = fire & is_div(bus.op_sel) & (bus.src_b != '0);

    // 33b sign/zero-extended operands let one signed multiplier serve MULT and MULTU
    assign mul_signed = (bus.op_sel == HILO_MULT);
    assign mul_a      = {mul_signed & bus.src_a[DW-1], bus.src_a};
    assign mul_b      = {mul_signed & bus.src_b[DW-1], bus.src_b};
    assign prod       = (2*DW)'(mul_a) * (2*DW)'(mul_b);

    div_radix2 #(.DW(DW), .CNT_W(CNT_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_en (bus.op_sel == HILO_DIV),
        .a         (bus.src_a),
        .b         (bus.src_b),
        .abort     (bus.flush),
        .done      (div_done),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    assign bus.stall = div_start | (state == ST_RUN);
    assign bus.busy  = (state == ST_RUN);
    assign bus.hi_o  = hi_q;
    assign bus.lo_o  = lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        case (bus.op_sel)
                            HILO_MULT, HILO_MULTU: {hi_q, lo_q} <= prod;
                            HILO_MTHI:             hi_q <= bus.src_a;
                            HILO_MTLO:             lo_q <= bus.src_a;
                            default:               ;
                        endcase
                        if (div_start) state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (div_done) begin
                        hi_q  <= div_rem;
                        lo_q  <= div_quo;
                        state <= ST_DONE;
                    end
                end
                // held divide leaves EX this cycle; its op_valid must not restart it
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes expected HI/LO and stall length,
// a negedge monitor pops on every retire/flush/reset and compares.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_muldiv_if #(.DW(32)) bus();

    hilo_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          scnt;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    exp_t cur;
    bit   pend = 1'b0;
    int   scnt = 0;

    always @(negedge clk) begin
        if (pend) begin
            checks += 3;
            if (bus.hi_o !== cur.hi) begin
                errors++;
                $display("FAIL hi: got %h want %h", bus.hi_o, cur.hi);
            end
            if (bus.lo_o !== cur.lo) begin
                errors++;
                $display("FAIL lo: got %h want %h", bus.lo_o, cur.lo);
            end
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_after: got %b want 0", bus.busy);
            end
            pend = 1'b0;
        end
        if (bus.stall === 1'b1) scnt++;
        if (rst || (bus.op_valid && (bus.flush || !bus.stall))) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire: got retire with empty queue want none");
            end else begin
                cur  = q.pop_front();
                pend = 1'b1;
                if (cur.scnt >= 0) begin
                    checks++;
                    if (scnt != cur.scnt) begin
                        errors++;
                        $display("FAIL stall_len: got %0d want %0d", scnt, cur.scnt);
                    end
                end
            end
            scnt = 0;
        end
    end

    task automatic do_reset(input int n);
        exp_t e;
        e.hi = '0; e.lo = '0; e.scnt = -1;
        mhi = '0; mlo = '0;
        for (int i = 0; i < n; i++) q.push_back(e);
        @(posedge clk); #1;
        rst = 1'b1; bus.op_valid = 1'b0; bus.flush = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // kill_at: stall-window cycle (0 = issue cycle) at which flush or rst hits, -1 = none
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int kill_at, input bit use_rst);
        exp_t        e;
        bit          divgo, fin;
        longint      sa, sb, p;
        logic [63:0] up;
        divgo = ((op == HILO_DIV) || (op == HILO_DIVU)) && (b != 0);
        if (kill_at >= 0) begin
            e.scnt = (divgo && !(kill_at == 0 && !use_rst)) ? kill_at + 1 : 0;
            if (use_rst) begin mhi = '0; mlo = '0; end
        end else begin
            e.scnt = divgo ? 33 : 0;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                HILO_MULT:  begin p = sa * sb; {mhi, mlo} = p; end
                HILO_MULTU: begin up = {32'b0, a} * {32'b0, b}; {mhi, mlo} = up; end
                HILO_DIV:   if (b != 0) begin mlo = 32'(sa / sb); mhi = 32'(sa % sb); end
                HILO_DIVU:  if (b != 0) begin mlo = a / b; mhi = a % b; end
                HILO_MTHI:  mhi = a;
                HILO_MTLO:  mlo = a;
                default:    ;
            endcase
        end
        e.hi = mhi; e.lo = mlo;
        q.push_back(e);

        @(posedge clk); #1;
        bus.op_valid = 1'b1; bus.op_sel = op; bus.src_a = a; bus.src_b = b;
        bus.flush = 1'b0; rst = 1'b0;
        for (int cyc = 0; ; cyc++) begin
            if (cyc == kill_at) begin
                if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
            end
            @(negedge clk);
            fin = rst || bus.flush || !bus.stall;
            if (fin) break;
            if (cyc > 100) begin
                checks++;
                errors++;
                $display("FAIL stall_timeout: got stall after %0d cycles want release", cyc);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.op_valid = 1'b0; bus.flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          k;
        bit          ur;
        bus.op_valid = 1'b0; bus.op_sel = '0; bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0;
        do_reset(3);

        issue(HILO_MULT,  32'hFFFF_FFFE, 32'd3,         -1, 0);
        issue(HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0);
        issue(HILO_DIV,   32'hFFFF_FFF9, 32'd2,         -1, 0);
        issue(HILO_DIVU,  32'd100,       32'd7,         -1, 0);
        issue(HILO_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        issue(HILO_DIV,   32'd5,         32'd0,         -1, 0);
        issue(HILO_DIVU,  32'd5,         32'd0,         -1, 0);
        issue(HILO_MTHI,  32'h1234,      32'd0,         -1, 0);
        issue(HILO_MTLO,  32'h5678,      32'd0,         -1, 0);
        issue(HILO_DIV,   32'd1000,      32'd3,         11, 0);
        issue(HILO_MTHI,  32'hDEAD,      32'd0,          0, 0);
        issue(HILO_DIV,   32'd1000,      32'd3,          0, 0);
        issue(HILO_DIVU,  32'hFFFF_0000, 32'd9,         -1, 0);
        issue(HILO_DIVU,  32'd77,        32'd5,         21, 1);
        issue(HILO_MTLO,  32'hCAFE,      32'd0,         -1, 0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                default: ;
            endcase
            k = -1; ur = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                ur = ($urandom_range(0, 3) == 0);
                k  = (((op == HILO_DIV) || (op == HILO_DIVU)) && b != 0) ? $urandom_range(0, 32) : 0;
            end
            issue(op, a, b, k, ur);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
